// File: rtl/sum_display.sv
// sum_display: 5-bit sum to two BCD digits via sequential double-dabble,
// driven onto a 4-digit multiplexed seven-segment display.
module sum_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sum,
  input  logic       update,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t      state;
  logic [4:0]  shreg;
  logic [7:0]  scratch;
  logic [2:0]  iter;
  logic [3:0]  ones_q;
  logic [3:0]  tens_q;
  logic [CW-1:0] rcnt;
  logic [1:0]  slot;
  logic [12:0] dd_next;
  logic [6:0]  seg_d;
  logic [3:0]  an_d;

  // Add 3 to every BCD nibble that is 5 or more.
  function automatic logic [7:0] adj(input logic [7:0] s);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = s[7:4];
    lo = s[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  // Active-low segment pattern for one BCD digit.
  function automatic logic [6:0] code(input logic [3:0] d);
    logic [6:0] c;
    unique case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // One double-dabble step: adjust, then shift left.
  always_comb begin
    dd_next = {adj(scratch), shreg} << 1;
  end

  // Conversion FSM; digit regs change only when leaving LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      shreg   <= '0;
      scratch <= '0;
      iter    <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (update) begin
            shreg   <= sum;
            scratch <= '0;
            iter    <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= dd_next[12:5];
          shreg   <= dd_next[4:0];
          iter    <= iter + 3'd1;
          if (iter == 3'd4) state <= LOAD;
        end
        LOAD: begin
          ones_q <= scratch[3:0];
          tens_q <= scratch[7:4];
          state  <= IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running refresh divider advancing the digit slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      slot <= '0;
    end else if (rcnt == TC) begin
      rcnt <= '0;
      slot <= slot + 2'd1;
    end else begin
      rcnt <= rcnt + CW'(1);
    end
  end

  // Slot decode: ones, blanked-if-zero tens, two dark digits.
  always_comb begin
    seg_d = 7'b1111111;
    an_d  = 4'b1111;
    unique case (1'b1)
      (slot == 2'd0): begin
        an_d  = 4'b1110;
        seg_d = code(ones_q);
      end
      (slot == 2'd1) && (tens_q != 4'd0): begin
        an_d  = 4'b1101;
        seg_d = code(tens_q);
      end
      default: ;
    endcase
  end

  // Registered display drive, one cycle behind the slot counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_sum_display.sv
// tb_sum_display: scoreboard bench for sum_display,
// directed cases plus randomized updates and resets.
module tb_sum_display;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [4:0] sum;
  logic       update;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int errors = 0;
  int checks = 0;

  sum_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .sum(sum),
    .update(update),
    .seg(seg),
    .an(an),
    .dp(dp),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [10];
  initial begin
    segtab[0] = 7'b1000000;
    segtab[1] = 7'b1111001;
    segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000;
    segtab[4] = 7'b0011001;
    segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010;
    segtab[7] = 7'b1111000;
    segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
  end

  // Behavioural model: displayed value, cycles since reset, busy timer.
  bit         started = 0;
  int         tick;
  int         timer;
  int         m_val;
  int         m_dig;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_busy;

  always @(posedge clk) begin
    int s;
    if (reset) begin
      started = 1;
      tick    = 0;
      timer   = 0;
      m_val   = 0;
      m_dig   = 0;
      e_seg   = 7'b1111111;
      e_an    = 4'b1111;
      e_busy  = 1'b0;
    end else if (started) begin
      s = (tick / DIV) % 4;
      tick++;
      e_seg = 7'b1111111;
      e_an  = 4'b1111;
      if (s == 0) begin
        e_an  = 4'b1110;
        e_seg = segtab[m_dig % 10];
      end else if (s == 1 && m_dig >= 10) begin
        e_an  = 4'b1101;
        e_seg = segtab[m_dig / 10];
      end
      if (timer == 0) begin
        if (update) begin
          m_val = int'(sum);
          timer = 6;
        end
      end else begin
        timer--;
        if (timer == 0) m_dig = m_val;
      end
      e_busy = (timer != 0);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checks += 4;
      if (seg !== e_seg) begin
        errors++;
        $display("FAIL seg t=%0t actual=%b required=%b", $time, seg, e_seg);
      end
      if (an !== e_an) begin
        errors++;
        $display("FAIL an t=%0t actual=%b required=%b", $time, an, e_an);
      end
      if (dp !== 1'b1) begin
        errors++;
        $display("FAIL dp t=%0t actual=%b required=1", $time, dp);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, e_busy);
      end
    end
  end

  task automatic pulse(input logic [4:0] v);
    @(negedge clk);
    update = 1'b1;
    sum    = v;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] a, input string nm);
    int k;
    k = 0;
    while (an !== a && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (an !== a) check({nm, "_timeout"}, int'(an), int'(a));
  endtask

  task automatic count_an(input logic [3:0] a, output int n);
    n = 0;
    repeat (4 * DIV + 4) begin
      @(negedge clk);
      if (an === a) n++;
    end
  endtask

  task automatic conv(input logic [4:0] v);
    pulse(v);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    update = 1'b1;
    sum    = 5'd31;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", int'(seg), 7'b1111111);
    check("rst_an", int'(an), 4'b1111);
    check("rst_busy", int'(busy), 0);
    check("rst_dp", int'(dp), 1);
    reset  = 1'b0;
    update = 1'b0;
    @(negedge clk);
    check("first_an", int'(an), 4'b1110);
    check("first_seg", int'(seg), 7'b1000000);

    pulse(5'd27);
    n = 0;
    repeat (20) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    check("busy_len27", n, 6);
    check("model27", m_dig, 27);
    wait_an(4'b1110, "s0_27");
    check("ones27", int'(seg), 7'b1111000);
    wait_an(4'b1101, "s1_27");
    check("tens27", int'(seg), 7'b0100100);
    wait_an(4'b1111, "s2_27");
    check("dark27", int'(seg), 7'b1111111);
    wait_an(4'b1110, "s0b_27");
    n = 0;
    while (an === 4'b1110 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("slot_len", n, DIV);

    conv(5'd7);
    count_an(4'b1101, n);
    check("blank7", n, 0);
    wait_an(4'b1110, "s0_7");
    check("ones7", int'(seg), 7'b1111000);

    conv(5'd0);
    wait_an(4'b1110, "s0_0");
    check("ones0", int'(seg), 7'b1000000);

    conv(5'd10);
    wait_an(4'b1101, "s1_10");
    check("tens10", int'(seg), 7'b1111001);
    wait_an(4'b1110, "s0_10");
    check("ones10", int'(seg), 7'b1000000);

    conv(5'd31);
    wait_an(4'b1101, "s1_31");
    check("tens31", int'(seg), 7'b0110000);
    wait_an(4'b1110, "s0_31");
    check("ones31", int'(seg), 7'b1111001);

    pulse(5'd27);
    n = int'(busy);
    @(negedge clk);
    n += int'(busy);
    update = 1'b1;
    sum    = 5'd3;
    @(negedge clk);
    n += int'(busy);
    update = 1'b0;
    repeat (16) begin
      @(negedge clk);
      n += int'(busy);
    end
    check("reject_busy", n, 6);
    check("reject_model", m_dig, 27);
    wait_an(4'b1101, "s1_rej");
    check("reject_tens", int'(seg), 7'b0100100);

    pulse(5'd19);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_model", m_dig, 0);
    wait_an(4'b1110, "s0_rst");
    check("midrst_ones", int'(seg), 7'b1000000);
    count_an(4'b1101, n);
    check("midrst_blank", n, 0);

    pulse(5'd5);
    repeat (5) @(negedge clk);
    pulse(5'd18);
    check("b2b_busy", int'(busy), 1);
    check("b2b_first", m_dig, 5);
    repeat (8) @(negedge clk);
    check("b2b_model", m_dig, 18);
    wait_an(4'b1101, "s1_18");
    check("tens18", int'(seg), 7'b1111001);
    wait_an(4'b1110, "s0_18");
    check("ones18", int'(seg), 7'b0000000);

    repeat (600) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 149) == 0);
      update = ($urandom_range(0, 5) == 0);
      sum    = 5'($urandom);
    end
    @(negedge clk);
    reset  = 1'b0;
    update = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
